// File: rtl/cpu_cu_param.sv
// cpu_cu_param -- parametrised Moore control unit for the 16-bit CPU family.
//
// Sits between the instruction register and the execution unit / memory and
// issues one control word per state. Memory states (FETCH, LOAD, STO, LDI)
// stall on mem_rdy. A watchdog counter sends the sequencer to BUSERR if the
// memory stays silent too long. HALT resumes on go. ILLEGAL and BUSERR are
// left only through reset.
//
// Ports:
//   clk, reset_n          clock (rising edge), async active-low reset
//   IR[IW-1:0]            instruction: opcode IR[IW-1:IW-7], fields a/b/c
//   N, Z, C               ALU status, latched by the flag-setting ALU ops
//   mem_rdy               memory completes the current access this cycle
//   go                    resume pulse while in HALT
//   W_addr/R_addr/S_addr  register file write/read/source addresses
//   adr_sel .. rw_en      single-bit control strobes
//   alu_op[3:0]           ALU opcode
//   status[7:0]           LED state display
//   bus_err               high while in BUSERR
module cpu_cu_param #(
    parameter  int AW  = 3,
    parameter  int TMO = 15,
    parameter  int CW  = 8,
    localparam int IW  = 7 + 3 * AW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [IW-1:0] IR,
    input  logic          N,
    input  logic          Z,
    input  logic          C,
    input  logic          mem_rdy,
    input  logic          go,
    output logic [AW-1:0] W_addr,
    output logic [AW-1:0] R_addr,
    output logic [AW-1:0] S_addr,
    output logic          adr_sel,
    output logic          s_sel,
    output logic          pc_ld,
    output logic          pc_inc,
    output logic          pc_sel,
    output logic          ir_ld,
    output logic          mw_en,
    output logic          rw_en,
    output logic [3:0]    alu_op,
    output logic [7:0]    status,
    output logic          bus_err
);

    // Execute states are encoded with their 5-bit status code so the status
    // display is simply {flags, state}.
    typedef enum logic [4:0] {
        S_ADD  = 5'd0,  S_SUB  = 5'd1,  S_CMP  = 5'd2,  S_MOV  = 5'd3,
        S_SHL  = 5'd4,  S_SHR  = 5'd5,  S_INC  = 5'd6,  S_DEC  = 5'd7,
        S_LOAD = 5'd8,  S_STO  = 5'd9,  S_LDI  = 5'd10, S_HALT = 5'd11,
        S_JE   = 5'd12, S_JNE  = 5'd13, S_JC   = 5'd14, S_JMP  = 5'd15,
        S_JN   = 5'd16, S_NOP  = 5'd17,
        S_RESET = 5'd18, S_FETCH = 5'd19, S_DECODE = 5'd20,
        S_ILL   = 5'd21, S_BUSERR = 5'd22
    } state_t;

    localparam logic [CW-1:0] TMO_C   = CW'(TMO);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    state_t        state_q, state_d;
    logic [2:0]    flags_q, flags_d;     // {ps_N, ps_Z, ps_C}
    logic [CW-1:0] cnt_q, cnt_d;

    logic [6:0]    opcode;
    logic [AW-1:0] fa, fb, fc;
    logic          is_mem;
    state_t        mem_next;

    assign opcode = IR[IW-1 -: 7];
    assign fa     = IR[3*AW-1 -: AW];
    assign fb     = IR[2*AW-1 -: AW];
    assign fc     = IR[AW-1:0];

    always_comb begin
        state_d  = state_q;
        flags_d  = flags_q;
        cnt_d    = '0;               // any non-stall cycle clears the watchdog
        is_mem   = 1'b0;
        mem_next = S_FETCH;
        W_addr   = '0;
        R_addr   = '0;
        S_addr   = '0;
        adr_sel  = 1'b0;
        s_sel    = 1'b0;
        pc_ld    = 1'b0;
        pc_inc   = 1'b0;
        pc_sel   = 1'b0;
        ir_ld    = 1'b0;
        mw_en    = 1'b0;
        rw_en    = 1'b0;
        alu_op   = 4'b0000;
        bus_err  = 1'b0;
        status   = {flags_q, state_q};

        case (state_q)
            S_RESET: begin
                status  = 8'hFF;
                state_d = S_FETCH;
            end
            S_FETCH: begin
                status   = 8'h80;
                ir_ld    = mem_rdy;
                pc_inc   = mem_rdy;
                is_mem   = 1'b1;
                mem_next = S_DECODE;
            end
            S_DECODE: begin
                status = 8'hC0;
                // 70..7F map directly onto execute codes 0..15.
                if (opcode[6:4] == 3'b111) state_d = state_t'({1'b0, opcode[3:0]});
                else if (opcode == 7'h6F)  state_d = S_JN;
                else if (opcode == 7'h6E)  state_d = S_NOP;
                else                       state_d = S_ILL;
            end
            S_ADD, S_SUB, S_CMP: begin
                R_addr  = fb;
                S_addr  = fc;
                alu_op  = (state_q == S_ADD) ? 4'b0100 : 4'b0101;
                W_addr  = (state_q == S_CMP) ? '0 : fa;
                rw_en   = (state_q != S_CMP);
                flags_d = {N, Z, C};
                state_d = S_FETCH;
            end
            S_MOV, S_SHL, S_SHR, S_INC, S_DEC: begin
                W_addr = fa;
                S_addr = fc;
                rw_en  = 1'b1;
                case (state_q)
                    S_SHL:   alu_op = 4'b0111;
                    S_SHR:   alu_op = 4'b0110;
                    S_INC:   alu_op = 4'b0010;
                    S_DEC:   alu_op = 4'b0011;
                    default: alu_op = 4'b0000;
                endcase
                if (state_q != S_MOV) flags_d = {N, Z, C};
                state_d = S_FETCH;
            end
            S_LOAD: begin
                W_addr  = fa;
                R_addr  = fc;
                adr_sel = 1'b1;
                s_sel   = 1'b1;
                rw_en   = mem_rdy;
                is_mem  = 1'b1;
            end
            S_STO: begin
                R_addr  = fa;
                S_addr  = fc;
                adr_sel = 1'b1;
                mw_en   = 1'b1;      // held for the whole stall
                is_mem  = 1'b1;
            end
            S_LDI: begin
                W_addr = fa;
                s_sel  = 1'b1;
                rw_en  = mem_rdy;
                pc_inc = mem_rdy;
                is_mem = 1'b1;
            end
            S_HALT: if (go) state_d = S_FETCH;
            S_JE: begin
                pc_ld   = flags_q[1];
                state_d = S_FETCH;
            end
            S_JNE: begin
                pc_ld   = ~flags_q[1];
                state_d = S_FETCH;
            end
            S_JC: begin
                pc_ld   = flags_q[0];
                state_d = S_FETCH;
            end
            S_JN: begin
                pc_ld   = flags_q[2];
                state_d = S_FETCH;
            end
            S_JMP: begin
                S_addr  = fc;
                pc_ld   = 1'b1;
                pc_sel  = 1'b1;
                state_d = S_FETCH;
            end
            S_NOP: state_d = S_FETCH;
            S_ILL: status = 8'hF0;
            S_BUSERR: begin
                status  = 8'hE0;
                bus_err = 1'b1;
            end
            default: state_d = S_RESET;
        endcase

        // Shared stall/timeout handling; a ready in the timeout cycle wins.
        if (is_mem) begin
            if (mem_rdy) begin
                state_d = mem_next;
            end else if (cnt_q == TMO_C) begin
                state_d = S_BUSERR;
            end else begin
                state_d = state_q;
                cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_RESET;
            flags_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_cpu_cu_param.sv
module tb_cpu_cu_param;
    localparam int AW   = 3;
    localparam int TMO  = 15;
    localparam int CW   = 8;
    localparam int IW   = 7 + 3 * AW;
    localparam int FW   = 3 * AW;
    localparam int EW   = 3 * AW + 8 + 4 + 8 + 1;
    localparam int NCYC = 4000;

    localparam int P_RST = 0, P_FET = 1, P_DEC = 2, P_EXE = 3, P_ILL = 4, P_BUS = 5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [IW-1:0] IR;
    logic          N, Z, C, mem_rdy, go;
    logic [AW-1:0] W_addr, R_addr, S_addr;
    logic          adr_sel, s_sel, pc_ld, pc_inc, pc_sel, ir_ld, mw_en, rw_en;
    logic [3:0]    alu_op;
    logic [7:0]    status;
    logic          bus_err;

    cpu_cu_param #(.AW(AW), .TMO(TMO), .CW(CW)) dut (
        .clk(clk), .reset_n(reset_n), .IR(IR), .N(N), .Z(Z), .C(C),
        .mem_rdy(mem_rdy), .go(go),
        .W_addr(W_addr), .R_addr(R_addr), .S_addr(S_addr),
        .adr_sel(adr_sel), .s_sel(s_sel), .pc_ld(pc_ld), .pc_inc(pc_inc),
        .pc_sel(pc_sel), .ir_ld(ir_ld), .mw_en(mw_en), .rw_en(rw_en),
        .alu_op(alu_op), .status(status), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    int opc_tab [18] = '{'h70, 'h71, 'h72, 'h73, 'h74, 'h75, 'h76, 'h77,
                         'h78, 'h79, 'h7A, 'h7B, 'h7C, 'h7D, 'h7E, 'h7F,
                         'h6F, 'h6E};
    int alu_tab [8]  = '{4, 5, 5, 0, 7, 6, 2, 3};

    logic [EW-1:0] exp_q [$];
    int            cyc_q [$];
    int            vectors = 0;
    int            miscompares = 0;

    function automatic logic [IW-1:0] gen_ir();
        logic [6:0] opc;
        if ($urandom_range(0, 24) == 0) opc = 7'($urandom_range(0, 'h6D));
        else                            opc = 7'(opc_tab[$urandom_range(0, 17)]);
        return {opc, FW'($urandom)};
    endfunction

    task automatic chk(input logic ok, input string name);
        vectors++;
        if (ok !== 1'b1) begin
            miscompares++;
            $display("FAIL %s at %0t: status %h bus_err %b", name, $time, status, bus_err);
        end
    endtask

    function automatic logic ctl_zero();
        return ({W_addr, R_addr, S_addr, adr_sel, s_sel, pc_ld, pc_inc, pc_sel,
                 ir_ld, mw_en, rw_en, alu_op} == '0);
    endfunction

    initial begin
        logic [EW-1:0] e, a;
        int            cy;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                cy = cyc_q.pop_front();
                a  = {W_addr, R_addr, S_addr, adr_sel, s_sel, pc_ld, pc_inc, pc_sel,
                      ir_ld, mw_en, rw_en, alu_op, status, bus_err};
                vectors++;
                if (a !== e) begin
                    miscompares++;
                    $display("FAIL ctl_word cycle %0d: got %h expected %h (W R S strobes alu status berr)",
                             cy, a, e);
                end
            end
        end
    end

    initial begin
        int         ph, op, cnt, stuck, stall_left;
        logic [2:0] fl;
        int         nph, nop, ncnt;
        logic [2:0] nfl;
        logic [AW-1:0] fa, fb, fc, w, r, s;
        logic       adr, ssel, pld, pinc, psel, irld, mw, rw, be;
        logic [3:0] alu;
        logic [7:0] st;
        logic       rst;

        reset_n = 1'b0; IR = '0; N = 0; Z = 0; C = 0; mem_rdy = 0; go = 0;
        ph = P_RST; op = 0; cnt = 0; fl = 3'b000; stuck = 0; stall_left = 0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            stuck = (ph == P_ILL || ph == P_BUS) ? stuck + 1 : 0;
            rst = (cyc < 2) || ($urandom_range(0, 199) == 0) || (stuck >= 6);
            reset_n = ~rst;
            if (ph == P_FET || ph == P_RST) IR = gen_ir();
            {N, Z, C} = 3'($urandom);
            if (stall_left > 0) begin
                mem_rdy = 1'b0;
                stall_left--;
            end else begin
                if ($urandom_range(0, 39) == 0) stall_left = $urandom_range(12, 18);
                mem_rdy = ($urandom_range(0, 3) != 0);
            end
            go = ($urandom_range(0, 3) == 0);
            if (rst) begin
                ph = P_RST; fl = 3'b000; cnt = 0; stuck = 0;
            end
            #1;
            fa = IR[3*AW-1 -: AW]; fb = IR[2*AW-1 -: AW]; fc = IR[AW-1:0];
            w = '0; r = '0; s = '0; alu = 4'd0; be = 1'b0;
            {adr, ssel, pld, pinc, psel, irld, mw, rw} = 8'h00;
            nph = ph; nop = op; nfl = fl; ncnt = 0;
            st = 8'h00;
            case (ph)
                P_RST: begin st = 8'hFF; nph = P_FET; end
                P_FET: begin st = 8'h80; irld = mem_rdy; pinc = mem_rdy; end
                P_DEC: begin
                    st = 8'hC0;
                    nop = -1;
                    for (int i = 0; i < 18; i++) if (int'(IR[IW-1 -: 7]) == opc_tab[i]) nop = i;
                    nph = (nop < 0) ? P_ILL : P_EXE;
                end
                P_EXE: begin
                    st = {fl, 5'(op)};
                    nph = P_FET;
                    if (op <= 7) begin
                        alu = 4'(alu_tab[op]);
                        s = fc;
                        if (op <= 2) r = fb;
                        if (op != 2) begin w = fa; rw = 1'b1; end
                        if (op != 3) nfl = {N, Z, C};
                    end
                    case (op)
                        8:  begin w = fa; r = fc; adr = 1; ssel = 1; rw = mem_rdy; end
                        9:  begin r = fa; s = fc; adr = 1; mw = 1; end
                        10: begin w = fa; ssel = 1; rw = mem_rdy; pinc = mem_rdy; end
                        11: nph = go ? P_FET : P_EXE;
                        12: pld = fl[1];
                        13: pld = ~fl[1];
                        14: pld = fl[0];
                        15: begin s = fc; pld = 1; psel = 1; end
                        16: pld = fl[2];
                        default: ;
                    endcase
                end
                P_ILL: st = 8'hF0;
                default: begin st = 8'hE0; be = 1'b1; end
            endcase
            if (ph == P_FET || (ph == P_EXE && op >= 8 && op <= 10)) begin
                if (mem_rdy)         nph = (ph == P_FET) ? P_DEC : P_FET;
                else if (cnt == TMO) nph = P_BUS;
                else begin nph = ph; ncnt = cnt + 1; end
            end
            exp_q.push_back({w, r, s, adr, ssel, pld, pinc, psel, irld, mw, rw, alu, st, be});
            cyc_q.push_back(cyc);
            if (!rst) begin
                ph = nph; op = nop; fl = nfl; cnt = ncnt;
            end
        end
        @(negedge clk);
        #3;

        @(negedge clk);
        reset_n = 1'b0; mem_rdy = 1'b0; go = 1'b0;
        #1;
        chk(ctl_zero() && status == 8'hFF && bus_err == 1'b0, "reset_state");
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk(status == 8'hFF, "reset_hold");
        for (int i = 0; i <= TMO; i++) begin
            @(negedge clk);
            #1;
            chk(status == 8'h80 && !ir_ld && !pc_inc && !bus_err, "fetch_stall");
        end
        @(negedge clk);
        #1;
        chk(bus_err == 1'b1 && status == 8'hE0 && ctl_zero(), "wait_expired");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_rdy = 1'b1; go = 1'b1;
            #1;
            chk(bus_err == 1'b1 && status == 8'hE0, "buserr_sticky");
        end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk(ctl_zero() && status == 8'hFF && bus_err == 1'b0, "buserr_reset_exit");
        @(negedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
